inst_encoder_loader: RTL and testbench

//  Encoder counterpart of the RV32I control decoder: turns field-level instruction requests into 32-bit words.

---
 rtl/inst_encoder_loader_pkg.sv | 19 +
 rtl/inst_encoder_loader_if.sv | 19 +
 rtl/inst_encoder_loader_encode.sv | 34 +++
 rtl/inst_encoder_loader.sv | 86 ++++++++
 tb/tb_inst_encoder_loader.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/inst_encoder_loader_pkg.sv
// inst_encoder_loader_pkg: class codes, opcodes, fixed instruction words and loader states
package inst_encoder_loader_pkg;
    typedef enum logic [3:0] {
        C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_LUI, C_AUIPC, C_JAL, C_JALR, C_SYSTEM, C_FENCE
    } cls_e;
    typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_HALT, S_DONE} state_e;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [31:0] W_ECALL  = 32'h00000073;
    localparam logic [31:0] W_EBREAK = 32'h00100073;
    localparam logic [31:0] W_FENCE  = 32'h0FF0000F;
endpackage

// File: rtl/inst_encoder_loader_if.sv
// inst_encoder_loader_if: request, control and instruction-memory write signals of the loader
interface inst_encoder_loader_if #(parameter int ADDR_W = 10);
    logic              start, flush, in_valid, in_ready, in_f7b5;
    logic [3:0]        in_class;
    logic [4:0]        in_rd, in_rs1, in_rs2;
    logic [2:0]        in_funct3;
    logic [31:0]       in_imm, mem_wdata;
    logic              mem_we, mem_ready, done, err;
    logic [ADDR_W-1:0] mem_addr;
    logic [ADDR_W:0]   count;
    modport slave (
        input  start, flush, in_valid, in_class, in_rd, in_rs1, in_rs2, in_funct3, in_f7b5, in_imm, mem_ready,
        output in_ready, mem_we, mem_addr, mem_wdata, count, done, err
    );
    modport master (
        output start, flush, in_valid, in_class, in_rd, in_rs1, in_rs2, in_funct3, in_f7b5, in_imm, mem_ready,
        input  in_ready, mem_we, mem_addr, mem_wdata, count, done, err
    );
endinterface

// File: rtl/inst_encoder_loader_encode.sv
// inst_encode: combinational RV32I field-to-word encoder; legal=0 for unknown classes
module inst_encode import inst_encoder_loader_pkg::*; (
    input  logic [3:0]  cls,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic        f7b5,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        legal
);
    logic [6:0] f7;
    assign f7 = {1'b0, f7b5, 5'b0};
    always_comb begin
        word  = '0;
        legal = 1'b1;
        case (cls)
            C_R:      word = {f7, rs2, rs1, funct3, rd, OP_R};
            C_I:      word = (funct3[1:0] == 2'b01) ? {f7, imm[4:0], rs1, funct3, rd, OP_I}
                                                    : {imm[11:0], rs1, funct3, rd, OP_I};
            C_LOAD:   word = {imm[11:0], rs1, funct3, rd, OP_LOAD};
            C_STORE:  word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
            C_BRANCH: word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_BRANCH};
            C_LUI:    word = {imm[31:12], rd, OP_LUI};
            C_AUIPC:  word = {imm[31:12], rd, OP_AUIPC};
            C_JAL:    word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
            C_JALR:   word = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
            C_SYSTEM: word = imm[0] ? W_EBREAK : W_ECALL;
            C_FENCE:  word = W_FENCE;
            default:  legal = 1'b0;
        endcase
    end
endmodule

// File: rtl/inst_encoder_loader.sv
// inst_encoder_loader: encodes field requests into RV32I words, buffers them and writes instruction memory
// INST_LOADER_HALT_EN: append an EBREAK after the drained program before reporting done
module inst_encoder_loader import inst_encoder_loader_pkg::*; #(
    parameter int ADDR_W     = 10,
    parameter int BASE_ADDR  = 0,
    parameter int FIFO_DEPTH = 4
) (
    input logic                  clk,
    input logic                  rst,
    inst_encoder_loader_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    state_e            state, state_n, drain_exit;
    logic [31:0]       fifo [FIFO_DEPTH];
    logic [PW:0]       wp, rp;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   cnt;
    logic [31:0]       enc;
    logic              ovf, err_q, legal, empty, full, accept, fire, last;

    inst_encode u_enc (
        .cls(bus.in_class), .rd(bus.in_rd), .rs1(bus.in_rs1), .rs2(bus.in_rs2),
        .funct3(bus.in_funct3), .f7b5(bus.in_f7b5), .imm(bus.in_imm), .word(enc), .legal(legal)
    );

    assign empty  = wp == rp;
    assign full   = (wp[PW] != rp[PW]) && (wp[PW-1:0] == rp[PW-1:0]);
    assign accept = bus.in_valid && bus.in_ready;
    assign fire   = bus.mem_we && bus.mem_ready;
    assign last   = addr == '1;

    assign bus.in_ready  = (state == S_RUN) && !full && !ovf;
    assign bus.mem_we    = (state == S_HALT) || (!empty && (state == S_RUN || state == S_DRAIN));
    assign bus.mem_wdata = (state == S_HALT) ? W_EBREAK : empty ? '0 : fifo[rp[PW-1:0]];
    assign bus.mem_addr  = addr;
    assign bus.count     = cnt;
    assign bus.done      = state == S_DONE;
    assign bus.err       = err_q;

`ifdef INST_LOADER_HALT_EN
    assign drain_exit = ovf ? S_DONE : S_HALT;
`else
    assign drain_exit = S_DONE;
`endif

    always_comb begin
        state_n = bus.start                       ? S_RUN      :
                  (state == S_RUN && bus.flush)   ? S_DRAIN    :
                  (state == S_DRAIN && empty)     ? drain_exit :
                  (state == S_HALT && fire)       ? S_DONE     : state;
    end

    always_ff @(posedge clk) state <= rst ? S_IDLE : state_n;

    always_ff @(posedge clk) begin
        if (accept && legal)
            fifo[wp[PW-1:0]] <= enc;
    end

    always_ff @(posedge clk) begin
        if (rst || bus.start) begin
            wp    <= '0;
            rp    <= '0;
            addr  <= BASE;
            cnt   <= '0;
            ovf   <= 1'b0;
            err_q <= 1'b0;
        end else begin
            if (fire) begin
                addr <= addr + 1'b1;
                cnt  <= cnt + 1'b1;
            end
            // writing the top address ends the program: the buffer and any same-cycle push are dropped
            if (fire && last) begin
                ovf <= 1'b1;
                wp  <= '0;
                rp  <= '0;
            end else begin
                if (accept && legal) wp <= wp + 1'b1;
                if (fire && !empty) rp <= rp + 1'b1;
            end
            if ((accept && !legal) || (fire && last)) err_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_inst_encoder_loader.sv
// tb_inst_encoder_loader: directed + randomized checks of the loader against a field-level reference model
module tb_inst_encoder_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        sel = 1'b0, valid = 1'b0, start = 1'b0, flush = 1'b0, f7b5 = 1'b0, mready = 1'b1, rmode = 1'b0;
    logic [3:0]  cls = '0;
    logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
    logic [2:0]  f3 = '0;
    logic [31:0] imm = '0;

    inst_encoder_loader_if #(.ADDR_W(10)) bus();
    inst_encoder_loader_if #(.ADDR_W(2))  bus2();
    inst_encoder_loader #(.ADDR_W(10)) dut  (.clk(clk), .rst(rst), .bus(bus));
    inst_encoder_loader #(.ADDR_W(2))  dut2 (.clk(clk), .rst(rst), .bus(bus2));

    assign bus.start = start && !sel;   assign bus2.start = start && sel;
    assign bus.flush = flush && !sel;   assign bus2.flush = flush && sel;
    assign bus.in_valid = valid && !sel; assign bus2.in_valid = valid && sel;
    assign bus.in_class = cls;  assign bus2.in_class = cls;
    assign bus.in_rd = rd;      assign bus2.in_rd = rd;
    assign bus.in_rs1 = rs1;    assign bus2.in_rs1 = rs1;
    assign bus.in_rs2 = rs2;    assign bus2.in_rs2 = rs2;
    assign bus.in_funct3 = f3;  assign bus2.in_funct3 = f3;
    assign bus.in_f7b5 = f7b5;  assign bus2.in_f7b5 = f7b5;
    assign bus.in_imm = imm;    assign bus2.in_imm = imm;
    assign bus.mem_ready = mready; assign bus2.mem_ready = mready;

    logic        rdy, we, dn, er;
    logic [31:0] addr_o, wdata, cnt;
    assign rdy    = sel ? bus2.in_ready : bus.in_ready;
    assign we     = sel ? bus2.mem_we : bus.mem_we;
    assign dn     = sel ? bus2.done : bus.done;
    assign er     = sel ? bus2.err : bus.err;
    assign addr_o = sel ? 32'(bus2.mem_addr) : 32'(bus.mem_addr);
    assign wdata  = sel ? bus2.mem_wdata : bus.mem_wdata;
    assign cnt    = sel ? 32'(bus2.count) : 32'(bus.count);

    int checks = 0, errors = 0, next_addr = 0;
    logic [63:0] cap_q[$], exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // reference encoding built from the instruction-format field positions
    function automatic logic [31:0] ref_word(input int c, input logic [4:0] d, s1, s2,
                                             input logic [2:0] f, input logic b5, input logic [31:0] i);
        logic [31:0] rf = (32'(s1) << 15) | (32'(f) << 12) | (32'(d) << 7);
        logic [31:0] hi = b5 ? 32'h4000_0000 : 32'h0;
        case (c)
            0:  return hi | (32'(s2) << 20) | rf | 32'h33;
            1:  return ((f == 3'd1 || f == 3'd5) ? (hi | ((i & 32'h1F) << 20)) : ((i & 32'hFFF) << 20)) | rf | 32'h13;
            2:  return ((i & 32'hFFF) << 20) | rf | 32'h03;
            3:  return (((i >> 5) & 32'h7F) << 25) | (32'(s2) << 20) | (32'(s1) << 15) | (32'(f) << 12)
                       | ((i & 32'h1F) << 7) | 32'h23;
            4:  return (((i >> 12) & 1) << 31) | (((i >> 5) & 32'h3F) << 25) | (32'(s2) << 20) | (32'(s1) << 15)
                       | (32'(f) << 12) | (((i >> 1) & 32'hF) << 8) | (((i >> 11) & 1) << 7) | 32'h63;
            5:  return (i & 32'hFFFF_F000) | (32'(d) << 7) | 32'h37;
            6:  return (i & 32'hFFFF_F000) | (32'(d) << 7) | 32'h17;
            7:  return (((i >> 20) & 1) << 31) | (((i >> 1) & 32'h3FF) << 21) | (((i >> 11) & 1) << 20)
                       | (((i >> 12) & 32'hFF) << 12) | (32'(d) << 7) | 32'h6F;
            8:  return ((i & 32'hFFF) << 20) | (32'(s1) << 15) | (32'(d) << 7) | 32'h67;
            9:  return i[0] ? 32'h0010_0073 : 32'h0000_0073;
            10: return 32'h0FF0_000F;
            default: return 32'h0;
        endcase
    endfunction

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic expw(input logic [31:0] w);
        exp_q.push_back({32'(next_addr), w});
        next_addr++;
    endtask

    task automatic expect_halt();
`ifdef INST_LOADER_HALT_EN
        expw(32'h0010_0073);
`endif
    endtask

    task automatic send(input int c, input logic [4:0] d, s1, s2, input logic [2:0] f, input logic b5,
                        input logic [31:0] i, input logic has_exp, input logic [31:0] want);
        int n = 0;
        logic acc = 1'b0;
        cls = 4'(c); rd = d; rs1 = s1; rs2 = s2; f3 = f; f7b5 = b5; imm = i; valid = 1'b1;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = rdy;
            sync();
            n++;
        end
        valid = 1'b0;
        chk("accept", 32'(acc), 1);
        if (has_exp) expw(want);
    endtask

    task automatic send_rand(input logic has_exp);
        int c = $urandom_range(0, 10);
        logic [4:0] d = 5'($urandom), s1 = 5'($urandom), s2 = 5'($urandom);
        logic [2:0] f = 3'($urandom);
        logic b = 1'($urandom);
        logic [31:0] i = $urandom;
        send(c, d, s1, s2, f, b, i, has_exp, ref_word(c, d, s1, s2, f, b, i));
    endtask

    task automatic start_pulse();
        start = 1'b1;
        sync();
        start = 1'b0;
        next_addr = 0;
    endtask

    task automatic flush_pulse();
        flush = 1'b1;
        sync();
        flush = 1'b0;
    endtask

    task automatic check_writes(input string tag);
        int n = 0;
        logic [63:0] a, e;
        while (cap_q.size() < exp_q.size() && n < 500) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk({tag, "_nwrites"}, 32'(cap_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && cap_q.size() > 0) begin
            a = cap_q.pop_front();
            e = exp_q.pop_front();
            chk({tag, "_addr"}, a[63:32], e[63:32]);
            chk({tag, "_data"}, a[31:0], e[31:0]);
        end
        exp_q.delete();
        cap_q.delete();
        sync();
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!dn && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done"}, 32'(dn), 1);
        sync();
    endtask

    task automatic chk_reset(input string t);
        chk({t, "_in_ready"}, 32'(rdy), 0);
        chk({t, "_mem_we"}, 32'(we), 0);
        chk({t, "_mem_addr"}, addr_o, 0);
        chk({t, "_mem_wdata"}, wdata, 0);
        chk({t, "_count"}, cnt, 0);
        chk({t, "_done"}, 32'(dn), 0);
        chk({t, "_err"}, 32'(er), 0);
    endtask

    // memory-side monitor: records completed writes and checks outputs hold during stalls
    logic        stall_prev = 1'b0;
    logic [31:0] sa, sd;
    always @(negedge clk) begin
        if (stall_prev) begin
            chk("stall_we", 32'(we), 1);
            chk("stall_addr", addr_o, sa);
            chk("stall_data", wdata, sd);
        end
        if (we && mready && !rst) cap_q.push_back({addr_o, wdata});
        stall_prev = we && !mready && !rst && !start;
        sa = addr_o;
        sd = wdata;
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rmode) mready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_reset("rst");
        rst = 1'b0;
        sync();
        flush_pulse();
        chk_reset("idle_flush");
        start_pulse();
        send(0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0, 1'b1, 32'h0020_81B3);
        send(1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5, 1'b1, 32'h0050_0093);
        check_writes("t1");
        chk("t1_count", cnt, 2);
        send(3, 5'd0, 5'd1, 5'd2, 3'd2, 1'b0, 32'd8, 1'b1, 32'h0020_A423);
        send(4, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'd8, 1'b1, 32'h0020_8463);
        send(7, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd16, 1'b1, 32'h0100_00EF);
        check_writes("t2");
        chk("t2_count", cnt, 5);
        start_pulse();
        mready = 1'b0;
        repeat (4) send_rand(1'b1);
        @(negedge clk);
        chk("t3_full_ready", 32'(rdy), 0);
        repeat (6) @(negedge clk);
        chk("t3_still_full", 32'(rdy), 0);
        chk("t3_no_write", 32'(cap_q.size()), 0);
        sync();
        mready = 1'b1;
        repeat (2) send_rand(1'b1);
        check_writes("t3");
        chk("t3_count", cnt, 6);
        send(12, 5'd1, 5'd1, 5'd1, 3'd0, 1'b0, 32'd0, 1'b0, 32'h0);
        @(negedge clk);
        chk("t4_err", 32'(er), 1);
        repeat (3) @(negedge clk);
        chk("t4_no_write", 32'(cap_q.size()), 0);
        sync();
        send_rand(1'b1);
        check_writes("t4");
        chk("t4_count", cnt, 7);
        mready = 1'b0;
        repeat (2) send_rand(1'b1);
        flush_pulse();
        mready = 1'b1;
        expect_halt();
        check_writes("t5");
        wait_done("t5");
        chk("t5_count", cnt, 32'(next_addr));
        chk("t5_in_ready", 32'(rdy), 0);
        flush_pulse();
        chk("t5_flush_done_kept", 32'(dn), 1);
        start_pulse();
        chk("t6_err_clear", 32'(er), 0);
        chk("t6_done_clear", 32'(dn), 0);
        chk("t6_count_clear", cnt, 0);
        rmode = 1'b1;
        repeat (24) send_rand(1'b1);
        flush_pulse();
        expect_halt();
        check_writes("t6");
        rmode = 1'b0;
        mready = 1'b1;
        wait_done("t6");
        chk("t6_count", cnt, 32'(next_addr));
        sel = 1'b1;
        start_pulse();
        repeat (4) send_rand(1'b1);
        send_rand(1'b0);
        check_writes("t7");
        chk("t7_err", 32'(er), 1);
        chk("t7_in_ready", 32'(rdy), 0);
        chk("t7_count", cnt, 4);
        start_pulse();
        mready = 1'b0;
        repeat (2) send_rand(1'b0);
        flush_pulse();
        chk("t8_pending_we", 32'(we), 1);
        rst = 1'b1;
        sync();
        chk_reset("t8_rst");
        rst = 1'b0;
        sync();
        chk_reset("t8_idle");
        chk("t8_no_write", 32'(cap_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
